uart_tx_ctrl: RTL and testbench

Frame controller and serializer for the UART transmitter. Accepts a parallel byte with a one-cycle valid strobe and sequences start, data (LSB first), optional parity and stop phases. Each cycle it drives the output-mux select, the current serial data bit and the parity bit into the downstream TX output mux/register stage. Runs on the TX (baud) clock, one bit per CLK cycle.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_serializer.sv | 46 ++++
 rtl/uart_tx_ctrl.sv | 97 +++++++++
 tb/tb_uart_tx_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: output-mux select codes,
// transmit FSM states and parity-type encodings.
package uart_pkg;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// ser_data is the shift-register LSB; ser_done marks the final data bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  input  logic                  cnt_clr,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= load_data;
    end else if (shift) begin
      shift_q <= shift_q >> 1;
    end
  end

  // The FSM never shifts on the last bit, so the counter stops at LAST_BIT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (shift) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ser_data = shift_q[0];
  assign ser_done = (cnt_q == LAST_BIT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, LSB-first data, optional
// parity and stop phases, one bit per CLK, driving the downstream TX mux.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  tx_state_e state_q, state_d;
  logic      accept;
  logic      par_en_q, par_typ_q, data_par_q;
  logic      ser_shift, cnt_clr, ser_done;

  // Request handshake: Data_Valid is a one-cycle strobe with no ready signal.
  // It is taken only in IDLE or STOP; in any other state it is dropped.
  assign accept = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      data_par_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        data_par_q <= ^P_DATA;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mux_sel   = SEL_STOP;
    ser_shift = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        mux_sel = SEL_START;
        cnt_clr = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        mux_sel = SEL_DATA;
        if (ser_done) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          ser_shift = 1'b1;
        end
      end
      ST_PARITY: begin
        mux_sel = SEL_PAR;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = accept ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .load_data (P_DATA),
    .shift     (ser_shift),
    .cnt_clr   (cnt_clr),
    .ser_data  (ser_data),
    .ser_done  (ser_done)
  );

  // Odd parity is the inverted data XOR; both terms are registered at accept.
  assign par_bit   = data_par_q ^ (par_typ_q == PAR_ODD);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a frame-level model predicts every
// cycle's outputs, and a monitor compares them on the falling clock edge.
module tb_uart_tx_ctrl;

  localparam int DW = 8;
  localparam int W  = 6;  // {busy, sel[1:0], chk_ser, ser, par}

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [1:0]    mux_sel;
  logic          ser_data, par_bit, busy;
  logic [2:0]    dbg_state;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .mux_sel(mux_sel),
    .ser_data(ser_data), .par_bit(par_bit), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- model / scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [4:0]   plan[$];     // {busy, sel, chk_ser, ser} per future cycle
  logic [4:0]   cur;         // record for the cycle currently in progress
  logic         model_par;
  int           chk_cnt  = 0;
  int           pass_cnt = 0;

  localparam logic [4:0] IDLE_REC = 5'b0_01_0_0;

  function automatic void build_frame(input logic [DW-1:0] d, input logic pe);
    plan.push_back(5'b1_00_0_0);
    for (int i = 0; i < DW; i++) plan.push_back({1'b1, 2'b10, 1'b1, d[i]});
    if (pe) plan.push_back(5'b1_11_0_0);
    plan.push_back(5'b1_01_0_0);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic dv, input logic [DW-1:0] d,
                      input logic pe, input logic pt);
    logic [4:0] nxt;
    @(negedge CLK);
    #1;
    Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    if (dv && cur[3:2] == 2'b01 && plan.size() == 0) begin
      build_frame(d, pe);
      model_par = (($countones(d) % 2) == 1) ^ pt;
    end
    nxt = (plan.size() != 0) ? plan.pop_front() : IDLE_REC;
    cur = nxt;
    exp_q.push_back({nxt, model_par});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Issue a frame and step until its STOP cycle is in progress.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    step(1'b1, d, pe, pt);
    for (int i = 0; i < DW + 4 && cur[3:2] != 2'b01; i++)
      step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string name);
    chk_cnt++;
    if ({mux_sel, busy, ser_data, par_bit} === 5'b01_0_0_0) pass_cnt++;
    else $display("FAIL %s got mux=%b busy=%b ser=%b par=%b exp mux=01 busy=0 ser=0 par=0",
                  name, mux_sel, busy, ser_data, par_bit);
  endtask

  task automatic mid_reset();
    @(negedge CLK);
    #2;
    RST = 1'b0;
    Data_Valid = 1'b0;
    exp_q.delete();
    plan.delete();
    #1;
    check_reset_vals("mid_frame_reset");
    repeat (2) @(negedge CLK);
    #1;
    RST = 1'b1;
    cur = IDLE_REC;
    model_par = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e, g;
    forever begin
      @(negedge CLK);
      if (RST && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {busy, mux_sel, e[2], (e[2] ? ser_data : e[1]), par_bit};
        chk_cnt++;
        if (g === e) pass_cnt++;
        else $display("FAIL cycle_out t=%0t got busy/sel/chk/ser/par=%b exp=%b",
                      $time, g, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cur = IDLE_REC;
    model_par = 1'b0;
    #12;
    check_reset_vals("reset_state");
    @(negedge CLK);
    #1;
    RST = 1'b1;

    idle(20);
    send(8'hA5, 1'b1, 1'b0);  idle(2);
    send(8'hA5, 1'b1, 1'b1);  idle(2);
    send(8'h01, 1'b0, 1'b0);  idle(3);

    // Back-to-back: second request lands in the STOP cycle.
    send(8'h55, 1'b1, 1'b0);
    send(8'hAA, 1'b1, 1'b0);  idle(2);

    // Request during DATA must be ignored.
    step(1'b1, 8'h0F, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < DW + 4 && cur[3:2] != 2'b01; i++) idle(1);
    idle(2);

    // Reset during data bit 3, then a fresh frame.
    step(1'b1, 8'hC3, 1'b1, 1'b1);
    idle(4);
    mid_reset();
    send(8'h3C, 1'b1, 1'b0);  idle(2);

    // Randomized frames with random gaps and spurious mid-frame strobes.
    for (int f = 0; f < 40; f++) begin
      step(1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < DW + 4 && cur[3:2] != 2'b01; i++)
        step($urandom_range(0, 3) == 0, DW'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end

    idle(2);
    @(negedge CLK);
    #2;
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain got=%0d pending exp=0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
